leakyrelu_arbiter: RTL and testbench

Shares one LeakyReLU datapath between NUM_REQ upstream requesters using round-robin arbitration with valid/ready handshakes. It sits between multiple PE output lanes and the activation stage. Each accepted sample is transformed and placed in a single output register, tagged with the requester ID. That register is held under downstream backpressure until it is consumed.

---
 rtl/leakyrelu_arbiter.sv | 103 ++++++++++
 tb/tb_leakyrelu_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/leakyrelu_arbiter.sv
// Purpose: round-robin arbiter sharing one LeakyReLU datapath among NUM_REQ requesters; result tagged with requester id.
// Latency: 1 cycle from requester handshake to o_valid; 1 sample/cycle when i_ready stays high.
// Backpressure: result register holds while o_valid & !i_ready and no grant is issued; option macro LEAKYRELU_ARB_PRIO0_EN gives requester 0 strict priority.
module leakyrelu_arbiter #(
    parameter int DATA_WIDTH           = 16,
    parameter int NUM_REQ              = 4,
    parameter int ID_WIDTH             = 2,
    parameter int NEGATIVE_SLOPE_SHIFT = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [NUM_REQ-1:0]            i_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data_bus,
    output logic [NUM_REQ-1:0]            o_ready,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data_bus,
    output logic [ID_WIDTH-1:0]           o_id,
    input  logic                          i_ready
);

    logic [DATA_WIDTH-1:0]        data_arr [NUM_REQ];
    logic [ID_WIDTH-1:0]          rr_ptr;
    logic                         can_accept;
    logic                         grant_vld;
    logic                         prio_hit;
    logic [ID_WIDTH-1:0]          grant_idx;
    logic signed [DATA_WIDTH-1:0] sel_data;
    logic signed [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]        result;
    logic [ID_WIDTH-1:0]          next_ptr;

    // Unpack the flat request bus so the winner can be selected by index.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_arr[k] = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Reset gating keeps o_ready low while rst_n is asserted.
    assign can_accept = rst_n & i_en & (~o_valid | i_ready);

    // Grant search: first valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int                  idx_int;
        logic [ID_WIDTH-1:0] cand;
        grant_vld = 1'b0;
        prio_hit  = 1'b0;
        grant_idx = '0;
        idx_int   = 0;
        cand      = '0;
        if (can_accept) begin
`ifdef LEAKYRELU_ARB_PRIO0_EN
            if (i_valid[0]) begin
                grant_vld = 1'b1;
                prio_hit  = 1'b1;
            end
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                idx_int = (int'(rr_ptr) + i) % NUM_REQ;
                cand    = ID_WIDTH'(idx_int);
                if (!grant_vld && i_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // One-hot grant; only ever set for a valid requester.
    always_comb begin
        o_ready = '0;
        if (grant_vld) begin
            o_ready[grant_idx] = 1'b1;
        end
    end

    // LeakyReLU: negative samples are arithmetically shifted, flooring toward -inf.
    assign sel_data = data_arr[grant_idx];
    assign shifted  = sel_data >>> NEGATIVE_SLOPE_SHIFT;
    assign result   = sel_data[DATA_WIDTH-1] ? shifted : sel_data;
    assign next_ptr = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Output register and round-robin pointer; a grant overwrites, a bare drain clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_id       <= '0;
            rr_ptr     <= '0;
        end else if (grant_vld) begin
            o_valid    <= 1'b1;
            o_data_bus <= result;
            o_id       <= grant_idx;
            if (!prio_hit) begin
                rr_ptr <= next_ptr;
            end
        end else if (o_valid && i_ready) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_id       <= '0;
        end
    end

endmodule

// File: tb/tb_leakyrelu_arbiter.sv
// Purpose: directed bench for leakyrelu_arbiter with a scoreboard queue and an output monitor.
// Latency: expected results are queued at the grant and popped when the DUT output is consumed.
// Backpressure: stalls are driven through i_ready; the monitor only pops on o_valid & i_ready.
module tb_leakyrelu_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_en = 1'b0;
    logic           i_ready = 1'b0;
    logic [NR-1:0]  i_valid = '0;
    logic [DW-1:0]  data [NR];
    logic [NR*DW-1:0] i_data_bus;
    logic [NR-1:0]  o_ready;
    logic           o_valid;
    logic [DW-1:0]  o_data_bus;
    logic [IW-1:0]  o_id;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } exp_t;

    exp_t sb[$];

    logic [DW-1:0] arith_in  [5] = '{16'h0040, 16'hFFC0, 16'hFFFF, 16'h8000, 16'h0000};
    logic [DW-1:0] arith_exp [5] = '{16'h0040, 16'hFFFE, 16'hFFFF, 16'hFC00, 16'h0000};

    assign i_data_bus = {data[3], data[2], data[1], data[0]};

    leakyrelu_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ(NR),
        .ID_WIDTH(IW),
        .NEGATIVE_SLOPE_SHIFT(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_en(i_en),
        .i_valid(i_valid),
        .i_data_bus(i_data_bus),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .o_data_bus(o_data_bus),
        .o_id(o_id),
        .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] oh2i(input logic [NR-1:0] v);
        oh2i = '0;
        for (int k = 0; k < NR; k++) begin
            if (v[k]) oh2i = IW'(k);
        end
    endfunction

    // One accepting cycle: drive, check grant at negedge, queue the expected result.
    task automatic step(input logic [NR-1:0] v, input logic en, input logic rdy,
                        input logic [NR-1:0] exp_rdy, input logic [DW-1:0] exp_val);
        exp_t e;
        i_valid = v;
        i_en    = en;
        i_ready = rdy;
        @(negedge clk);
        chk("grant", 32'(o_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            e.d  = exp_val;
            e.id = oh2i(exp_rdy);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rr_burst();
        step(4'hF, 1'b1, 1'b1, 4'b0001, 16'h0100);
        step(4'hF, 1'b1, 1'b1, 4'b0010, 16'h0101);
        step(4'hF, 1'b1, 1'b1, 4'b0100, 16'h0102);
        step(4'hF, 1'b1, 1'b1, 4'b1000, 16'h0103);
        step(4'hF, 1'b1, 1'b1, 4'b0001, 16'h0100);
    endtask

    task automatic chk_out(input string name, input logic v, input logic [DW-1:0] d, input logic [IW-1:0] id);
        chk({name, "_valid"}, 32'(o_valid), 32'(v));
        chk({name, "_data"}, 32'(o_data_bus), 32'(d));
        chk({name, "_id"}, 32'(o_id), 32'(id));
    endtask

    // Monitor: grant legality every cycle, and result comparison on each consumption.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("ready_subset", 32'(o_ready & ~i_valid), 32'd0);
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got data %h id %0d, expected no output", o_data_bus, o_id);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(o_data_bus), 32'(e.d));
                    chk("out_id", 32'(o_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NR; k++) data[k] = 16'h0100 + 16'(k);

        // Reset held with all requesters valid: grants must stay off.
        rst_n   = 1'b0;
        i_en    = 1'b1;
        i_valid = 4'hF;
        i_ready = 1'b1;
        @(negedge clk);
        chk_out("reset", 1'b0, 16'h0000, 2'd0);
        chk("reset_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin from requester 0.
        rr_burst();

        // Backpressure: result frozen, no grants.
        for (int c = 0; c < 3; c++) begin
            step(4'hF, 1'b1, 1'b0, 4'b0000, 16'h0000);
            chk_out("hold", 1'b1, 16'h0100, 2'd0);
        end
        // Ready returns: grant in the same cycle, no bubble.
        step(4'hF, 1'b1, 1'b1, 4'b0010, 16'h0101);
        chk_out("nobubble", 1'b1, 16'h0101, 2'd1);

        // Enable low: drain then empty, pointer unchanged.
        step(4'hF, 1'b0, 1'b1, 4'b0000, 16'h0000);
        chk_out("drain", 1'b0, 16'h0000, 2'd0);
        step(4'hF, 1'b0, 1'b1, 4'b0000, 16'h0000);
        chk("drain_idle", 32'(o_valid), 32'd0);
        step(4'hF, 1'b1, 1'b1, 4'b0100, 16'h0102);

        // Arithmetic on requester 2 alone.
        for (int a = 0; a < 5; a++) begin
            data[2] = arith_in[a];
            step(4'b0100, 1'b1, 1'b1, 4'b0100, arith_exp[a]);
        end
        data[2] = 16'h0102;

        // Fairness between requesters 1 and 3, then requester 0 joins at rr_ptr=2.
        step(4'b1010, 1'b1, 1'b1, 4'b1000, 16'h0103);
        step(4'b1010, 1'b1, 1'b1, 4'b0010, 16'h0101);
        step(4'b1010, 1'b1, 1'b1, 4'b1000, 16'h0103);
        step(4'b1010, 1'b1, 1'b1, 4'b0010, 16'h0101);
        step(4'b1011, 1'b1, 1'b1, 4'b1000, 16'h0103);
        step(4'b1011, 1'b1, 1'b1, 4'b0001, 16'h0100);
        step(4'b1011, 1'b1, 1'b1, 4'b0010, 16'h0101);

        // Mid-stream reset with a held result; pointer would otherwise be at 3.
        step(4'hF, 1'b1, 1'b1, 4'b0100, 16'h0102);
        i_valid = 4'h0;
        i_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        i_valid = 4'hF;
        i_ready = 1'b1;
        #1;
        chk_out("midreset", 1'b0, 16'h0000, 2'd0);
        chk("midreset_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_burst();

        // Drain everything and confirm nothing is left outstanding.
        step(4'h0, 1'b1, 1'b1, 4'b0000, 16'h0000);
        step(4'h0, 1'b1, 1'b1, 4'b0000, 16'h0000);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk_out("final", 1'b0, 16'h0000, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
